// File: rtl/cpu_loader.sv
// ---------------------------------------------------------------------------
// cpu_loader
//   Boot/run sequencer placed in front of the cpu top. A valid/ready word
//   stream is written first into instruction memory (32-bit words), then into
//   data memory (64-bit words). After that the cpu enable is held high for a
//   programmed number of cycles, and completion is reported.
//
//   Optional build macro: CPU_LOADER_DUMP_EN
//     When defined, a DUMP state follows RUN. It streams every data-memory
//     word out on an m_valid/m_ready port before DONE is reached.
//
// Ports
//   clk, arst               clock and asynchronous active-high reset
//   start, run_cycles       begin a sequence and set the RUN length (sampled on start)
//   s_valid/s_data/s_last   inbound load stream; s_ready is high in the load phases
//   cpu_enable              high for exactly run_cycles cycles in RUN
//   addr_ext..wdata_ext     instruction memory port (byte address)
//   addr_ext_2..rdata_ext_2 data memory port (byte address)
//   busy, done, overflow    status; overflow is sticky until the next start
//   m_valid/m_data/m_last/m_ready  dump stream (CPU_LOADER_DUMP_EN only)
// ---------------------------------------------------------------------------
module cpu_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             s_valid,
    input  logic [63:0]      s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
`ifdef CPU_LOADER_DUMP_EN
    output logic             m_valid,
    output logic [63:0]      m_data,
    output logic             m_last,
    input  logic             m_ready,
`endif
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    // The word counter must be able to hold the capacity value itself, so
    // that a saturated counter keeps flagging "full" for every extra word.
    localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
    localparam int WC_W      = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
`ifdef CPU_LOADER_DUMP_EN
        S_DUMP,
`endif
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WC_W-1:0]   r_cnt;
    logic [CNT_W-1:0]  r_run;
    logic              r_overflow;

    logic              w_xfer;
    logic              w_i_full;
    logic              w_d_full;
    logic              w_start_ok;

    assign s_ready    = (r_state == S_LOAD_I) || (r_state == S_LOAD_D);
    assign w_xfer     = s_valid && s_ready;
    assign w_i_full   = (r_cnt == WC_W'(IMEM_WORDS));
    assign w_d_full   = (r_cnt == WC_W'(DMEM_WORDS));
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef CPU_LOADER_DUMP_EN
    logic              r_rd_pend;   // read issued last cycle, data arrives now
    logic              r_m_valid;
    logic [63:0]       r_m_data;
    logic              r_m_last;
    logic              w_ren2;
    logic              w_m_hs;

    // Only one read is ever outstanding: nothing is issued while a word is
    // in flight from memory or waiting on the output handshake.
    assign w_ren2  = (r_state == S_DUMP) && !r_m_valid && !r_rd_pend;
    assign w_m_hs  = r_m_valid && m_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    localparam state_t S_AFTER_RUN = S_DUMP;
`else
    logic              w_unused;
    assign w_unused = ^rdata_ext_2;
    localparam state_t S_AFTER_RUN = S_DONE;
`endif

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = S_LOAD_I;
            end
            S_LOAD_I: begin
                if (w_xfer && s_last) w_state_next = S_LOAD_D;
            end
            S_LOAD_D: begin
                if (w_xfer && s_last)
                    w_state_next = (r_run == '0) ? S_AFTER_RUN : S_RUN;
            end
            S_RUN: begin
                // r_run holds the number of RUN cycles still to go, including this one.
                if (r_run <= CNT_W'(1)) w_state_next = S_AFTER_RUN;
            end
`ifdef CPU_LOADER_DUMP_EN
            S_DUMP: begin
                if (w_m_hs && r_m_last) w_state_next = S_DONE;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, counters and status
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_run      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_cnt      <= '0;
                        r_run      <= run_cycles;
                        r_overflow <= 1'b0;
                    end
                end
                S_LOAD_I: begin
                    if (w_xfer) begin
                        if (w_i_full) r_overflow <= 1'b1;
                        if (s_last)
                            r_cnt <= '0;
                        else if (!w_i_full)
                            r_cnt <= r_cnt + WC_W'(1);
                    end
                end
                S_LOAD_D: begin
                    if (w_xfer) begin
                        if (w_d_full) r_overflow <= 1'b1;
                        if (s_last)
                            r_cnt <= '0;
                        else if (!w_d_full)
                            r_cnt <= r_cnt + WC_W'(1);
                    end
                end
                S_RUN: begin
                    r_run <= r_run - CNT_W'(1);
                end
`ifdef CPU_LOADER_DUMP_EN
                S_DUMP: begin
                    if (w_m_hs) begin
                        r_cnt <= r_m_last ? '0 : r_cnt + WC_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef CPU_LOADER_DUMP_EN
    // Dump output register: captures memory data one cycle after the read
    // and holds it until the consumer takes it.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rd_pend <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            r_rd_pend <= w_ren2;
            if (r_rd_pend) begin
                r_m_valid <= 1'b1;
                r_m_data  <= rdata_ext_2;
                r_m_last  <= (r_cnt == WC_W'(DMEM_WORDS - 1));
            end else if (w_m_hs) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end
    assign ren_ext_2 = w_ren2;
`else
    assign ren_ext_2 = 1'b0;
`endif

    // Memory ports: combinational from the registered state and counter.
    // Addresses and data are forced to zero outside the phases that use them.
    assign wen_ext     = (r_state == S_LOAD_I) && w_xfer && !w_i_full;
    assign ren_ext     = 1'b0;
    assign addr_ext    = (r_state == S_LOAD_I) ? (64'(r_cnt) << 2) : 64'd0;
    assign wdata_ext   = (r_state == S_LOAD_I) ? s_data[31:0] : 32'd0;

    assign wen_ext_2   = (r_state == S_LOAD_D) && w_xfer && !w_d_full;
`ifdef CPU_LOADER_DUMP_EN
    assign addr_ext_2  = ((r_state == S_LOAD_D) || (r_state == S_DUMP)) ?
                         (64'(r_cnt) << 3) : 64'd0;
`else
    assign addr_ext_2  = (r_state == S_LOAD_D) ? (64'(r_cnt) << 3) : 64'd0;
`endif
    assign wdata_ext_2 = (r_state == S_LOAD_D) ? s_data : 64'd0;

    assign cpu_enable  = (r_state == S_RUN);
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_cpu_loader.sv
// ---------------------------------------------------------------------------
// tb_cpu_loader
//   Directed bench for cpu_loader (IMEM_WORDS=4, DMEM_WORDS=4). Load-phase
//   cycles come from a vector table; RUN length, reset during RUN and the
//   optional dump stream are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] run_cycles = '0;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2 = '0;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef CPU_LOADER_DUMP_EN
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] dm [4];

    always #5 clk = ~clk;

    cpu_loader #(.IMEM_WORDS(4), .DMEM_WORDS(4), .CNT_W(32)) dut (
        .clk(clk), .arst(arst), .start(start), .run_cycles(run_cycles),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
`ifdef CPU_LOADER_DUMP_EN
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
`endif
        .busy(busy), .done(done), .overflow(overflow)
    );

    // Data memory model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (ren_ext_2) rdata_ext_2 <= dm[addr_ext_2[4:3]];
    end

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        l;
        logic        rdy;
        logic        we;
        logic [63:0] a;
        logic [31:0] wd;
        logic        we2;
        logic [63:0] a2;
        logic [63:0] wd2;
        logic        ovf;
    } vec_t;

    vec_t tv [20];

    function automatic vec_t mk(input logic v, input logic [63:0] d, input logic l,
                                input logic rdy, input logic we, input logic [63:0] a,
                                input logic [31:0] wd, input logic we2,
                                input logic [63:0] a2, input logic [63:0] wd2,
                                input logic ovf);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.rdy = rdy; r.we = we; r.a = a; r.wd = wd;
        r.we2 = we2; r.a2 = a2; r.wd2 = wd2; r.ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] rc);
        run_cycles = rc;
        start = 1'b1;
        tick();
        start = 1'b0;
        $display("start run_cycles=%0d", rc);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            s_valid = tv[i].v;
            s_data  = tv[i].d;
            s_last  = tv[i].l;
            #2;
            chk($sformatf("v%0d_s_ready", i),     64'(s_ready),   64'(tv[i].rdy));
            chk($sformatf("v%0d_wen_ext", i),     64'(wen_ext),   64'(tv[i].we));
            chk($sformatf("v%0d_addr_ext", i),    addr_ext,       tv[i].a);
            chk($sformatf("v%0d_wdata_ext", i),   64'(wdata_ext), 64'(tv[i].wd));
            chk($sformatf("v%0d_wen_ext_2", i),   64'(wen_ext_2), 64'(tv[i].we2));
            chk($sformatf("v%0d_addr_ext_2", i),  addr_ext_2,     tv[i].a2);
            chk($sformatf("v%0d_wdata_ext_2", i), wdata_ext_2,    tv[i].wd2);
            chk($sformatf("v%0d_overflow", i),    64'(overflow),  64'(tv[i].ovf));
            $display("vec %0d valid=%0b data=0x%0h last=%0b wen=%0b addr=0x%0h wen2=%0b addr2=0x%0h ovf=%0b",
                     i, s_valid, s_data, s_last, wen_ext, addr_ext, wen_ext_2, addr_ext_2, overflow);
            tick();
        end
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
    endtask

    // Count cpu_enable cycles until done, within a fixed cycle budget.
    task automatic wait_run(input int exp_cycles, input string tag);
        int  n = 0;
        logic seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (cpu_enable) n++;
            tick();
        end
        chk({tag, "_done_reached"}, 64'(seen), 64'd1);
        chk({tag, "_enable_cycles"}, 64'(n), 64'(exp_cycles));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        $display("run %s enable_cycles=%0d done=%0b", tag, n, done);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dm[i] = 64'hD0D0_0000_0000_0000 + 64'(i * 3 + 1);

        // A: basic load, run_cycles=5
        tv[0]  = mk(1, 64'h13,                  0, 1, 1, 64'd0,  32'h13, 0, 64'd0,  64'd0,  0);
        tv[1]  = mk(1, 64'h13,                  0, 1, 1, 64'd4,  32'h13, 0, 64'd0,  64'd0,  0);
        tv[2]  = mk(1, 64'h33,                  1, 1, 1, 64'd8,  32'h33, 0, 64'd0,  64'd0,  0);
        tv[3]  = mk(1, 64'h11,                  0, 1, 0, 64'd0,  32'h0,  1, 64'd0,  64'h11, 0);
        tv[4]  = mk(1, 64'h22,                  1, 1, 0, 64'd0,  32'h0,  1, 64'd8,  64'h22, 0);
        // B: run_cycles=0, s_valid toggling in the data phase
        tv[5]  = mk(1, 64'hAA,                  1, 1, 1, 64'd0,  32'hAA, 0, 64'd0,  64'd0,  0);
        tv[6]  = mk(1, 64'h100,                 0, 1, 0, 64'd0,  32'h0,  1, 64'd0,  64'h100, 0);
        tv[7]  = mk(0, 64'h0,                   0, 1, 0, 64'd0,  32'h0,  0, 64'd8,  64'd0,  0);
        tv[8]  = mk(1, 64'h200,                 0, 1, 0, 64'd0,  32'h0,  1, 64'd8,  64'h200, 0);
        tv[9]  = mk(0, 64'h0,                   0, 1, 0, 64'd0,  32'h0,  0, 64'd16, 64'd0,  0);
        tv[10] = mk(1, 64'h300,                 1, 1, 0, 64'd0,  32'h0,  1, 64'd16, 64'h300, 0);
        // C: six instruction words into a 4-word memory
        tv[11] = mk(1, 64'hFFFF_0000_0000_00A0, 0, 1, 1, 64'd0,  32'hA0, 0, 64'd0,  64'd0,  0);
        tv[12] = mk(1, 64'hFFFF_0000_0000_00A1, 0, 1, 1, 64'd4,  32'hA1, 0, 64'd0,  64'd0,  0);
        tv[13] = mk(1, 64'hFFFF_0000_0000_00A2, 0, 1, 1, 64'd8,  32'hA2, 0, 64'd0,  64'd0,  0);
        tv[14] = mk(1, 64'hFFFF_0000_0000_00A3, 0, 1, 1, 64'd12, 32'hA3, 0, 64'd0,  64'd0,  0);
        tv[15] = mk(1, 64'hFFFF_0000_0000_00A4, 0, 1, 0, 64'd16, 32'hA4, 0, 64'd0,  64'd0,  0);
        tv[16] = mk(1, 64'hFFFF_0000_0000_00A5, 1, 1, 0, 64'd16, 32'hA5, 0, 64'd0,  64'd0,  1);
        tv[17] = mk(1, 64'h55,                  1, 1, 0, 64'd0,  32'h0,  1, 64'd0,  64'h55, 1);
        // D: short load ahead of a reset during RUN (overflow cleared by start)
        tv[18] = mk(1, 64'h77,                  1, 1, 1, 64'd0,  32'h77, 0, 64'd0,  64'd0,  0);
        tv[19] = mk(1, 64'h88,                  1, 1, 0, 64'd0,  32'h0,  1, 64'd0,  64'h88, 0);

        // Reset values
        #3;
        chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
        chk("rst_s_ready",    64'(s_ready),    64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_done",       64'(done),       64'd0);
        chk("rst_overflow",   64'(overflow),   64'd0);
        chk("rst_wens",       64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        chk("rst_addr",       addr_ext | addr_ext_2, 64'd0);
        chk("rst_wdata",      64'(wdata_ext) | wdata_ext_2, 64'd0);
        $display("reset checked");
        @(negedge clk);
        arst = 1'b0;
        tick();

        // A
        do_start(32'd5);
        chk("A_busy_in_load", 64'(busy), 64'd1);
        run_vecs(0, 4);
        wait_run(5, "A");
        chk("A_overflow", 64'(overflow), 64'd0);

        // B
        do_start(32'd0);
        run_vecs(5, 10);
`ifndef CPU_LOADER_DUMP_EN
        chk("B_done_next_cycle", 64'(done), 64'd1);
`endif
        wait_run(0, "B");

        // C
        do_start(32'd2);
        run_vecs(11, 17);
        wait_run(2, "C");
        chk("C_overflow_sticky", 64'(overflow), 64'd1);

        // D: start ignored in RUN, then reset on the 3rd RUN cycle
        do_start(32'd10);
        run_vecs(18, 19);
        chk("D_run_cycle1_en", 64'(cpu_enable), 64'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("D_run_cycle3_en",    64'(cpu_enable), 64'd1);
        chk("D_start_ignored",    64'(s_ready),    64'd0);
        #2;
        arst = 1'b1;
        #1;
        chk("D_arst_cpu_enable", 64'(cpu_enable), 64'd0);
        chk("D_arst_busy",       64'(busy),       64'd0);
        chk("D_arst_done",       64'(done),       64'd0);
        chk("D_arst_s_ready",    64'(s_ready),    64'd0);
        $display("reset asserted during RUN cpu_enable=%0b busy=%0b", cpu_enable, busy);
        #3;
        arst = 1'b0;
        tick();
        chk("D_idle_busy", 64'(busy), 64'd0);
        chk("D_idle_done", 64'(done), 64'd0);

`ifdef CPU_LOADER_DUMP_EN
        begin
            int got = 0;
            int stall = 0;
            do_start(32'd1);
            run_vecs(18, 19);
            for (int c = 0; c < 300 && got < 4; c++) begin
                if (m_valid && got == 1 && stall < 3) begin
                    m_ready = 1'b0;
                    chk($sformatf("dump_stall%0d_data", stall), m_data, dm[1]);
                    stall++;
                end else begin
                    m_ready = 1'b1;
                end
                if (m_valid && m_ready) begin
                    chk($sformatf("dump_w%0d_data", got), m_data, dm[got]);
                    chk($sformatf("dump_w%0d_last", got), 64'(m_last), 64'(got == 3));
                    $display("dump word %0d data=0x%0h last=%0b", got, m_data, m_last);
                    got++;
                end
                tick();
            end
            m_ready = 1'b1;
            chk("dump_words", 64'(got), 64'd4);
            chk("dump_stalls", 64'(stall), 64'd3);
            chk("dump_done", 64'(done), 64'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
